seg_mux_decoder: RTL and testbench
==================================

SEG_MUX_DECODER -- requirements
Module: seg_mux_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4, giving the number of consecutive cycles a synchronized (an, seg) pair must hold before capture; legal range is 1..255.
REQ-002 The block SHALL have parameter STALE_CYC, default 100000, giving the number of cycles without a capture after which a digit's valid flag drops; legal range is >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port seg, input, 7 bits: active-low segments, with bit0=a through bit6=g.
REQ-006 The block SHALL have port an, input, 4 bits: active-low digit enables, with bit i selecting digit i.
REQ-007 The block SHALL have port digits, output, 16 bits: the decoded hex value of digit i on bits [4i+3:4i].
REQ-008 The block SHALL have port dig_valid, output, 4 bits: bit i set means digits[i] holds a fresh, legal capture.
REQ-009 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when all four digits have been captured since the last pulse.
REQ-010 The block SHALL have port pat_err, output, 1 bit: a one-cycle pulse on each stable illegal event.
REQ-011 The block SHALL have port err_cnt, output, 8 bits: a saturating count of pat_err pulses.

Function
REQ-012 seg and an SHALL each pass through a two-flop synchronizer; all later logic SHALL use only the synchronized values.
REQ-013 Decoding SHALL invert seg and match the result, as a 7-bit value g..a, against this table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71; any other value is illegal.
REQ-014 The capture FSM SHALL have the states IDLE, COUNT and HELD, with a stable counter that resets to 0 whenever the synchronized (an, seg) pair differs from its previous-cycle value.
REQ-015 The FSM SHALL go IDLE->COUNT on any change of the synchronized pair, and COUNT->IDLE on a further change before the count completes.
REQ-016 The FSM SHALL go COUNT->HELD once the pair has been unchanged for STABLE_CYC consecutive cycles, and HELD->COUNT on the next change; exactly one capture decision SHALL be made per entry into HELD.
REQ-017 The capture decision when an = 1111 (blank) SHALL be: no capture, no error.
REQ-018 The capture decision when an has more than one low bit SHALL be: pat_err pulse, and no digit affected.
REQ-019 The capture decision when exactly one bit i of an is low and the pattern is legal SHALL be: digits[i] loads the decoded value, dig_valid[i] is set, seen[i] is set, and the stale timer for digit i is cleared.
REQ-020 The capture decision when exactly one bit i of an is low and the pattern is illegal SHALL be: pat_err pulse, dig_valid[i] cleared, digits[i] unchanged.
REQ-021 Latency SHALL be STABLE_CYC+2 cycles from the pins settling to digits/dig_valid/pat_err being visible on the outputs.
REQ-022 frame_done SHALL pulse in the cycle after seen becomes 1111, and seen SHALL clear in that same cycle.
REQ-023 A capture landing on the clearing cycle of seen SHALL set its seen bit afresh.
REQ-024 Each digit SHALL have a stale timer, saturating at STALE_CYC; on reaching STALE_CYC, dig_valid[i] SHALL clear while digits[i] is held.
REQ-025 A capture and stale expiry in the same cycle SHALL resolve with the capture winning.
REQ-026 err_cnt SHALL increment on each pat_err and saturate at 255, never wrapping.
REQ-027 Simultaneous change of an and seg in the same cycle SHALL be treated as one change.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously clear digits=0000, dig_valid=0000, frame_done=0, pat_err=0, err_cnt=00, seen=0000, stable counter=0 and the stale timers, and set FSM=IDLE and the synchronizers to an=1111, seg=7F.
REQ-030 Reset asserted mid-COUNT SHALL abort the pending capture.
REQ-031 After rst_n is released, no capture SHALL occur until a pair has been held stable for STABLE_CYC cycles.

Verification
REQ-032 With STABLE_CYC=4, drive an=1110, seg=~7'h4F -> after 6 cycles, digits[3:0]=3 and dig_valid=0001, with no pat_err.
REQ-033 Scan the digits 1,2,3,4 on an bits 0..3, each held 10 cycles -> digits=16'h4321, dig_valid=1111, and one frame_done pulse one cycle after the fourth capture.
REQ-034 Drive an=1101, seg=~7'h00 held stable -> one pat_err pulse, dig_valid[1]=0, err_cnt=1; holding the same pair for 100 further cycles produces no further error.
REQ-035 Drive an=1100 with a legal seg -> pat_err pulses and digits is unchanged; toggle seg every 2 cycles with STABLE_CYC=4 -> no capture and no error.
REQ-036 Set STALE_CYC=50, capture digit 0, then blank the display -> dig_valid[0] falls exactly 50 cycles after the capture, and digits[3:0] is retained.
REQ-037 Force 300 illegal stable events -> err_cnt=255.
REQ-038 Pulse rst_n low mid-COUNT -> all outputs are at reset values immediately, and no capture follows.

Source files
------------

// File: rtl/seg_mux_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low 7-segment display bus.
// Each synchronized (an, seg) pair is captured only after it has held stable for STABLE_CYC cycles.
module seg_mux_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int STALE_CYC  = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic        frame_done,
  output logic        pat_err,
  output logic [7:0]  err_cnt,
  output logic [1:0]  dbg_state
);

  localparam int             TW       = $clog2(STALE_CYC + 1);
  localparam logic [TW-1:0]  STALE_T  = TW'(STALE_CYC);
  localparam logic [7:0]     DONE_CNT = 8'(STABLE_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HELD = 2'd2} state_t;

  logic [3:0]    an_s1_q, an_s2_q;
  logic [6:0]    seg_s1_q, seg_s2_q;
  logic [10:0]   pair_prev_q;
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    valid_q, valid_d;
  logic [3:0]    seen_q, seen_d;
  logic          fd_q, pe_q, pe_d;
  logic [7:0]    err_q, err_d;
  logic [TW-1:0] tmr_q [4];
  logic [TW-1:0] tmr_d [4];

  logic        change, done, decide, one_low, legal;
  logic [4:0]  dec;
  logic [3:0]  sel_mask, cap_mask, clr_mask;

  // Returns {legal, value} for an active-high g..a segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // cnt_d counts cycles the pair has stayed unchanged; the change cycle itself counts as the first.
  assign change = {an_s2_q, seg_s2_q} != pair_prev_q;
  assign cnt_d  = change ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
  assign done   = (cnt_d == DONE_CNT);

  always_comb begin
    state_d = state_q;
    decide  = 1'b0;
    case (state_q)
      IDLE: begin
        if (change) begin
          if (done) begin state_d = HELD; decide = 1'b1; end
          else state_d = COUNT;
        end
      end
      COUNT: begin
        if (done) begin state_d = HELD; decide = 1'b1; end
        else if (change) state_d = IDLE;
      end
      HELD: begin
        if (change) begin
          if (done) begin state_d = HELD; decide = 1'b1; end
          else state_d = COUNT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dec      = decode(~seg_s2_q);
  assign legal    = dec[4];
  assign sel_mask = ~an_s2_q;
  assign one_low  = $onehot(sel_mask);
  assign cap_mask = (decide && one_low && legal)  ? sel_mask : 4'b0000;
  assign clr_mask = (decide && one_low && !legal) ? sel_mask : 4'b0000;
  assign pe_d     = decide && (sel_mask != 4'b0000) && !(one_low && legal);
  assign err_d    = (pe_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  assign seen_d   = ((seen_q == 4'hF) ? 4'h0 : seen_q) | cap_mask;

  // A capture on the same cycle as stale expiry keeps the digit valid.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    for (int i = 0; i < 4; i++) begin
      tmr_d[i] = cap_mask[i] ? '0 : ((tmr_q[i] == STALE_T) ? tmr_q[i] : tmr_q[i] + 1'b1);
      if (cap_mask[i]) begin
        digits_d[4*i +: 4] = dec[3:0];
        valid_d[i]         = 1'b1;
      end else if (clr_mask[i] || tmr_d[i] == STALE_T) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q     <= 4'hF;
      an_s2_q     <= 4'hF;
      seg_s1_q    <= 7'h7F;
      seg_s2_q    <= 7'h7F;
      pair_prev_q <= {4'hF, 7'h7F};
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      digits_q    <= 16'h0000;
      valid_q     <= 4'h0;
      seen_q      <= 4'h0;
      fd_q        <= 1'b0;
      pe_q        <= 1'b0;
      err_q       <= 8'h00;
      for (int i = 0; i < 4; i++) tmr_q[i] <= '0;
    end else begin
      an_s1_q     <= an;
      an_s2_q     <= an_s1_q;
      seg_s1_q    <= seg;
      seg_s2_q    <= seg_s1_q;
      pair_prev_q <= {an_s2_q, seg_s2_q};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      fd_q        <= (seen_q == 4'hF);
      pe_q        <= pe_d;
      err_q       <= err_d;
      for (int i = 0; i < 4; i++) tmr_q[i] <= tmr_d[i];
    end
  end

  assign digits     = digits_q;
  assign dig_valid  = valid_q;
  assign frame_done = fd_q;
  assign pat_err    = pe_q;
  assign err_cnt    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Directed bench for seg_mux_decoder: stimulus pushes timestamped expected output snapshots,
// a negedge monitor pops one whenever the outputs show an event and compares.
module tb_seg_mux_decoder;

  localparam int W = 62;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic        frame_done, pat_err;
  logic [7:0]  err_cnt;
  logic [1:0]  dbg_state;

  seg_mux_decoder #(.STABLE_CYC(4), .STALE_CYC(50)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .digits(digits),
    .dig_valid(dig_valid), .frame_done(frame_done), .pat_err(pat_err),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [15:0]  m_digits;
  logic [3:0]   m_valid;
  logic [7:0]   m_err;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // snapshot = {cycle, frame_done, pat_err, err_cnt, dig_valid, digits}
  task automatic push_ev(input int when, input logic fd, input logic pe);
    exp_q.push_back({32'(when), fd, pe, m_err, m_valid, m_digits});
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] a, input logic [6:0] p, output int t0);
    an  = a;
    seg = ~p;
    t0  = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("queue_drain", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    an = 4'hF;
    seg = 7'h7F;
    m_digits = '0; m_valid = '0; m_err = '0;
    hold(3);
    rst_n = 1'b1;
    hold(3);
  endtask

  // monitor
  logic [15:0]  last_d;
  logic [3:0]   last_v;
  logic [W-1:0] act_w, exp_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_d = '0;
      last_v = '0;
    end else begin
      if (pat_err || frame_done || digits !== last_d || dig_valid !== last_v) begin
        act_w = {32'(cyc), frame_done, pat_err, err_cnt, dig_valid, digits};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", act_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (act_w !== exp_w) begin
            n_fail++;
            $display("FAIL event: got %0h expected %0h", act_w, exp_w);
          end
        end
      end
      last_d = digits;
      last_v = dig_valid;
    end
  end

  logic [6:0] pats [4];
  logic [3:0] a_sel;
  int t0, tc;

  initial begin
    pats = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    rst_n = 1'b0;
    an = 4'hF;
    seg = 7'h7F;
    m_digits = '0; m_valid = '0; m_err = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", digits, 0);
    check("rst_valid", dig_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pat_err", pat_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    hold(10);

    // single legal digit, latency STABLE_CYC+2
    drive(4'hE, 7'h4F, t0);
    m_digits = 16'h0003; m_valid = 4'h1;
    push_ev(t0 + 6, 1'b0, 1'b0);
    hold(5);
    check("lat_early_valid", dig_valid, 4'h0);
    hold(1);
    check("lat_valid", dig_valid, 4'h1);
    check("lat_digit", digits, 16'h0003);
    check("lat_no_err", pat_err, 1'b0);
    hold(8);
    do_reset();

    // scan 1,2,3,4 across the four digits
    for (int i = 0; i < 4; i++) begin
      a_sel = ~(4'b0001 << i);
      drive(a_sel, pats[i], t0);
      m_digits[4*i +: 4] = 4'(i + 1);
      m_valid[i] = 1'b1;
      push_ev(t0 + 6, 1'b0, 1'b0);
      if (i == 3) push_ev(t0 + 7, 1'b1, 1'b0);
      hold(10);
    end
    check("scan_digits", digits, 16'h4321);
    check("scan_valid", dig_valid, 4'hF);
    do_reset();

    // legal then illegal on digit 1, then hold the illegal pair
    drive(4'hD, 7'h5B, t0);
    m_digits[7:4] = 4'h2; m_valid[1] = 1'b1;
    push_ev(t0 + 6, 1'b0, 1'b0);
    hold(10);
    drive(4'hD, 7'h00, t0);
    m_valid[1] = 1'b0; m_err = 8'd1;
    push_ev(t0 + 6, 1'b0, 1'b1);
    hold(106);
    check("illegal_err_cnt", err_cnt, 8'd1);
    check("illegal_digits", digits, 16'h0020);

    // two digit enables low, then fast toggling
    drive(4'hC, 7'h06, t0);
    m_err = 8'd2;
    push_ev(t0 + 6, 1'b0, 1'b1);
    hold(10);
    check("multi_digits", digits, 16'h0020);
    for (int k = 0; k < 10; k++) begin
      drive(4'hE, (k % 2 == 1) ? 7'h5B : 7'h06, t0);
      hold(2);
    end
    check("toggle_err_cnt", err_cnt, 8'd2);
    check("toggle_valid", dig_valid, 4'h0);
    do_reset();

    // stale expiry after 50 cycles, value retained
    drive(4'hE, 7'h07, t0);
    tc = t0 + 6;
    m_digits = 16'h0007; m_valid = 4'h1;
    push_ev(tc, 1'b0, 1'b0);
    hold(10);
    drive(4'hF, 7'h00, t0);
    m_valid = 4'h0;
    push_ev(tc + 50, 1'b0, 1'b0);
    hold(60);
    check("stale_digits", digits, 16'h0007);
    check("stale_valid", dig_valid, 4'h0);
    do_reset();

    // 300 illegal stable events saturate err_cnt
    for (int k = 0; k < 300; k++) begin
      drive(4'hC, (k % 2 == 1) ? 7'h5B : 7'h06, t0);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      push_ev(t0 + 6, 1'b0, 1'b1);
      hold(6);
    end
    check("sat_err_cnt", err_cnt, 8'hFF);

    // reset in the middle of COUNT
    drive(4'hD, 7'h4F, t0);
    m_digits[7:4] = 4'h3; m_valid = 4'h2;
    push_ev(t0 + 6, 1'b0, 1'b0);
    hold(10);
    drive(4'hE, 7'h3F, t0);
    hold(3);
    check("pre_rst_state", dbg_state, 2'd1);
    #2;
    rst_n = 1'b0;
    an = 4'hF;
    seg = 7'h7F;
    #1;
    check("midrst_digits", digits, 0);
    check("midrst_valid", dig_valid, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_state", dbg_state, 0);
    m_digits = '0; m_valid = '0; m_err = '0;
    hold(3);
    rst_n = 1'b1;
    hold(20);
    check("post_rst_digits", digits, 0);
    check("post_rst_valid", dig_valid, 0);
    check("post_rst_state", dbg_state, 0);
    check("queue_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
